// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side icache request controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } ireq_state_t;

    // Default width of the dropped-response counter
    localparam int unsigned DROP_CNT_W_DEFAULT = 16;

    // State entered on reset; one dead cycle precedes the first request
    localparam ireq_state_t IREQ_RESET_STATE = IDLE;

    // State entered once a stale response is owed after a redirect
    localparam ireq_state_t IREQ_STALE_STATE = DROP;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/inst_req_ctrl.sv
// Instruction-cache request sequencer for the fetch stage: one outstanding
// request, stall generation, and stale-response filtering after redirects.
module inst_req_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = DROP_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  d_stall,
    input  logic                  jb_req,
    output logic                  inst_req,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic                  inst_second_ok_in,
    output logic                  f_stall,
    output logic                  fetch_data_ok,
    output logic                  fetch_second_ok,
    output logic                  fetch_valid,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    ireq_state_t state;
    ireq_state_t state_nxt;
    logic        drop_inc;
    logic        advance;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IREQ_RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch-side strobes derived from the current state and live inputs
    always_comb begin
        inst_req        = (state == REQ);
        fetch_data_ok   = inst_data_ok && (state == WAIT) && !jb_req;
        fetch_second_ok = inst_second_ok_in && fetch_data_ok;
        fetch_valid     = fetch_data_ok || ((state == HOLD) && !jb_req);
        advance         = fetch_valid && !d_stall;
        f_stall         = !(advance || jb_req);
    end

    // Next-state selection; a redirect always wins over stall or delivery
    always_comb begin
        state_nxt = state;
        drop_inc  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (inst_addr_ok && jb_req) state_nxt = IREQ_STALE_STATE;
                else if (inst_addr_ok)      state_nxt = WAIT;
            end
            WAIT: begin
                if (inst_data_ok && jb_req) begin
                    state_nxt = REQ;
                    drop_inc  = 1'b1;
                end else if (inst_data_ok && !d_stall) begin
                    state_nxt = REQ;
                end else if (inst_data_ok) begin
                    state_nxt = HOLD;
                end else if (jb_req) begin
                    state_nxt = IREQ_STALE_STATE;
                end
            end
            HOLD: begin
                if (jb_req) begin
                    state_nxt = REQ;
                    drop_inc  = 1'b1;
                end else if (!d_stall) begin
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (inst_data_ok) begin
                    state_nxt = REQ;
                    drop_inc  = 1'b1;
                end
            end
            default: state_nxt = IREQ_RESET_STATE;
        endcase
    end

    sat_counter #(
        .W(DROP_CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .clr_n(resetn),
        .inc  (drop_inc),
        .cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_inst_req_ctrl.sv
// Self-checking bench for inst_req_ctrl: directed vectors, a flag-based
// transaction model compared every cycle, and hand-computed spot checks.
module tb_inst_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        d_stall = 1'b0;
    logic        jb_req = 1'b0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic        inst_second_ok_in = 1'b0;

    logic        inst_req, f_stall, fetch_data_ok, fetch_second_ok, fetch_valid;
    logic [15:0] drop_cnt;
    logic        inst_req_w2, f_stall_w2, fdok_w2, fsok_w2, fvalid_w2;
    logic [1:0]  drop_cnt_w2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    inst_req_ctrl u_dut (
        .clk(clk), .resetn(resetn), .d_stall(d_stall), .jb_req(jb_req),
        .inst_req(inst_req), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_second_ok_in(inst_second_ok_in),
        .f_stall(f_stall), .fetch_data_ok(fetch_data_ok),
        .fetch_second_ok(fetch_second_ok), .fetch_valid(fetch_valid),
        .drop_cnt(drop_cnt)
    );

    inst_req_ctrl #(.DROP_CNT_W(2)) u_dut_w2 (
        .clk(clk), .resetn(resetn), .d_stall(d_stall), .jb_req(jb_req),
        .inst_req(inst_req_w2), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_second_ok_in(inst_second_ok_in),
        .f_stall(f_stall_w2), .fetch_data_ok(fdok_w2),
        .fetch_second_ok(fsok_w2), .fetch_valid(fvalid_w2),
        .drop_cnt(drop_cnt_w2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: request lifecycle as independent flags plus an unbounded drop tally
    logic m_known = 1'b0;
    logic m_dead = 1'b0, m_asking = 1'b0, m_owed = 1'b0, m_stale = 1'b0, m_held = 1'b0;
    int unsigned m_drops = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_known <= 1'b1; m_dead <= 1'b1; m_asking <= 1'b0; m_owed <= 1'b0;
            m_stale <= 1'b0; m_held <= 1'b0; m_drops <= 0;
        end else if (m_known) begin
            if (m_dead) begin
                m_dead <= 1'b0; m_asking <= 1'b1;
            end else if (m_asking) begin
                if (inst_addr_ok) begin
                    m_asking <= 1'b0; m_owed <= 1'b1; m_stale <= jb_req;
                end
            end else if (m_owed) begin
                if (inst_data_ok) begin
                    m_owed <= 1'b0; m_stale <= 1'b0;
                    if (m_stale || jb_req) begin
                        m_drops <= m_drops + 1; m_asking <= 1'b1;
                    end else if (d_stall) begin
                        m_held <= 1'b1;
                    end else begin
                        m_asking <= 1'b1;
                    end
                end else if (jb_req) begin
                    m_stale <= 1'b1;
                end
            end else if (m_held) begin
                if (jb_req) begin
                    m_drops <= m_drops + 1; m_held <= 1'b0; m_asking <= 1'b1;
                end else if (!d_stall) begin
                    m_held <= 1'b0; m_asking <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic e_dok, e_valid, e_stall;
        if (m_known) begin
            if ((m_dead || m_asking) && inst_data_ok)
                $error("protocol: data_ok while no request accepted");
            e_dok   = m_owed && !m_stale && inst_data_ok && !jb_req;
            e_valid = e_dok || (m_held && !jb_req);
            e_stall = !((e_valid && !d_stall) || jb_req);
            chk("inst_req",        {31'd0, inst_req},        {31'd0, m_asking});
            chk("fetch_data_ok",   {31'd0, fetch_data_ok},   {31'd0, e_dok});
            chk("fetch_second_ok", {31'd0, fetch_second_ok}, {31'd0, e_dok && inst_second_ok_in});
            chk("fetch_valid",     {31'd0, fetch_valid},     {31'd0, e_valid});
            chk("f_stall",         {31'd0, f_stall},         {31'd0, e_stall});
            chk("drop_cnt",        {16'd0, drop_cnt},        (m_drops > 65535) ? 32'd65535 : m_drops);
            chk("f_stall_w2",      {31'd0, f_stall_w2},      {31'd0, e_stall});
            chk("drop_cnt_w2",     {30'd0, drop_cnt_w2},     (m_drops > 3) ? 32'd3 : m_drops);
        end
    end

    // One cycle of stimulus; returns just after the following falling edge
    task automatic step(input logic rn, input logic ds, input logic jb,
                        input logic aok, input logic dok, input logic sok);
        @(posedge clk);
        #1;
        resetn = rn; d_stall = ds; jb_req = jb;
        inst_addr_ok = aok; inst_data_ok = dok; inst_second_ok_in = sok;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset, then basic fetch: addr_ok cycle 2, data_ok cycle 4
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);                      // cycle 0: IDLE
        chk("t1_idle_req", {31'd0, inst_req}, 0);
        chk("t1_idle_stall", {31'd0, f_stall}, 1);
        chk("t1_idle_valid", {31'd0, fetch_valid}, 0);
        chk("t1_idle_drop", {16'd0, drop_cnt}, 0);
        step(1, 0, 0, 0, 0, 0);                      // cycle 1
        chk("t1_c1_req", {31'd0, inst_req}, 1);
        step(1, 0, 0, 1, 0, 0);                      // cycle 2
        chk("t1_c2_req", {31'd0, inst_req}, 1);
        step(1, 0, 0, 0, 0, 0);                      // cycle 3
        chk("t1_c3_dok", {31'd0, fetch_data_ok}, 0);
        chk("t1_c3_stall", {31'd0, f_stall}, 1);
        step(1, 0, 0, 0, 1, 1);                      // cycle 4
        chk("t1_c4_dok", {31'd0, fetch_data_ok}, 1);
        chk("t1_c4_sok", {31'd0, fetch_second_ok}, 1);
        chk("t1_c4_stall", {31'd0, f_stall}, 0);
        step(1, 0, 0, 1, 0, 0);                      // cycle 5
        chk("t1_c5_req", {31'd0, inst_req}, 1);

        // Response during decode stall -> HOLD for 3 cycles
        step(1, 1, 0, 0, 1, 0);
        chk("t2_s0_valid", {31'd0, fetch_valid}, 1);
        chk("t2_s0_stall", {31'd0, f_stall}, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("t2_s1_stall", {31'd0, f_stall}, 1);
        step(1, 1, 0, 0, 0, 0);
        chk("t2_s2_valid", {31'd0, fetch_valid}, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_release_stall", {31'd0, f_stall}, 0);
        chk("t2_drop", {16'd0, drop_cnt}, 0);

        // Redirect in WAIT, stale data_ok two cycles later
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("t3_jb_stall", {31'd0, f_stall}, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1);
        chk("t3_stale_dok", {31'd0, fetch_data_ok}, 0);
        chk("t3_stale_sok", {31'd0, fetch_second_ok}, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t3_req_again", {31'd0, inst_req}, 1);
        chk("t3_drop", {16'd0, drop_cnt}, 1);

        // Redirect coincident with data_ok; then redirect in REQ without addr_ok
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        chk("t4_dok", {31'd0, fetch_data_ok}, 0);
        chk("t4_stall", {31'd0, f_stall}, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("t4_req", {31'd0, inst_req}, 1);
        chk("t4_drop", {16'd0, drop_cnt}, 2);
        step(1, 0, 0, 0, 0, 0);
        chk("t4_req_hold", {31'd0, inst_req}, 1);
        chk("t4_drop_same", {16'd0, drop_cnt}, 2);

        // Saturation of the 2-bit counter over five stale responses
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 0, 0);
            step(1, 0, 1, 0, 1, 0);
            step(1, 0, 0, 0, 0, 0);
            chk("t5_drop_w2", {30'd0, drop_cnt_w2}, (i < 3) ? i + 1 : 3);
            chk("t5_drop_w16", {16'd0, drop_cnt}, i + 1);
        end

        // Reset asserted in WAIT
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_wait_rst_req", {31'd0, inst_req}, 0);
        chk("t6_wait_rst_stall", {31'd0, f_stall}, 1);
        chk("t6_wait_rst_drop", {16'd0, drop_cnt}, 0);

        // Reset asserted in HOLD
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_hold_rst_valid", {31'd0, fetch_valid}, 0);
        chk("t6_hold_rst_dok", {31'd0, fetch_data_ok}, 0);
        chk("t6_hold_rst_stall", {31'd0, f_stall}, 1);
        chk("t6_hold_rst_drop_w2", {30'd0, drop_cnt_w2}, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_restart_req", {31'd0, inst_req}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_req_ctrl.md
Name: inst_req_ctrl

Overview:
- Sequences instruction-cache requests for the fetch stage over the sram-like req / addr_ok / data_ok handshake.
- Allows at most one outstanding request.
- Generates f_stall for the fetch PC flop and filtered data_ok/valid strobes for the fetch datapath.
- Discards stale responses after a jump/branch redirect.
- Sits between the fetch stage and the icache.

Parameters:
- DROP_CNT_W, 16: width of the saturating dropped-response counter.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- d_stall  in  1  decode stall; F->D flops hold.
- jb_req  in  1  redirect request; PC loads jb_addr this cycle. May stay high for several cycles; re-taking is idempotent.
- inst_req  out  1  request to icache.
- inst_addr_ok  in  1  icache accepted the address.
- inst_data_ok  in  1  icache response valid (rdata_1).
- inst_second_ok_in  in  1  icache second word valid.
- f_stall  out  1  hold the fetch PC flop.
- fetch_data_ok  out  1  filtered data_ok to fetch (live rdata usable).
- fetch_second_ok  out  1  inst_second_ok_in & fetch_data_ok.
- fetch_valid  out  1  fetch holds a valid, non-stale instruction this cycle (live or held).
- drop_cnt  out  DROP_CNT_W  saturating count of discarded responses.

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE, drop_cnt=0.
  - Outputs while in IDLE: inst_req=0, f_stall=1, fetch_data_ok=0, fetch_second_ok=0, fetch_valid=0.
  - Icache shares resetn, so no response from a pre-reset request can arrive.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- Outputs as a function of state:
  - inst_req = (state==REQ).
  - fetch_data_ok = inst_data_ok & (state==WAIT) & !jb_req.
  - fetch_valid = fetch_data_ok | ((state==HOLD) & !jb_req).
  - advance = fetch_valid & !d_stall.
  - f_stall = !(advance | jb_req).
- Transitions, first matching row wins:
  - IDLE -> REQ, unconditionally (one dead cycle after reset).
  - REQ:
    - addr_ok & jb_req -> DROP (the accepted address is stale).
    - addr_ok -> WAIT.
    - jb_req & !addr_ok -> REQ; PC takes jb_addr and the request continues with the new address, since the icache samples the address only at addr_ok.
    - else REQ.
  - WAIT:
    - data_ok & jb_req -> REQ, drop_cnt++.
    - data_ok & !d_stall -> REQ, PC advances.
    - data_ok & d_stall -> HOLD.
    - jb_req -> DROP.
    - else WAIT.
  - HOLD (the fetch stage keeps its registered copy of the instruction):
    - jb_req -> REQ, drop_cnt++.
    - !d_stall -> REQ, PC advances.
    - else HOLD.
  - DROP:
    - data_ok -> REQ, drop_cnt++; fetch_data_ok stays 0.
    - jb_req -> DROP; PC retargets. Still exactly one stale response is owed.
    - else DROP.
- Latency and rate:
  - Icache data_ok arrives >=1 cycle after addr_ok.
  - data_ok in IDLE or REQ is a protocol violation: it is ignored and flagged by a bench assertion.
  - Minimum request-to-request spacing is 2 cycles (REQ, WAIT with same-cycle data_ok, REQ).
- drop_cnt saturates at all-ones with no wrap.
- jb_req and d_stall together: the redirect wins and f_stall=0.

Decomposition:
- fetch_pkg:
  - typedef enum logic [2:0] ireq_state_t {IDLE, REQ, WAIT, HOLD, DROP}.
  - Redirect and handshake constants.
- One sub-module, sat_counter #(W): increment enable, synchronous active-low clear, saturating. Used for drop_cnt.

Test Plan:
- Reset release, addr_ok on cycle 2, data_ok on cycle 4, d_stall=0 -> inst_req high cycles 1-2; fetch_data_ok=1 and f_stall=0 on cycle 4 only; inst_req high again cycle 5.
- Response during d_stall: data_ok with d_stall=1 for 3 cycles -> HOLD; fetch_valid=1 and f_stall=1 for 3 cycles; f_stall drops on the cycle d_stall falls; drop_cnt=0.
- Redirect while in WAIT, data_ok 2 cycles later -> f_stall=0 on the jb_req cycle; DROP; fetch_data_ok stays 0; drop_cnt=1; next inst_req issues.
- Redirect same cycle as data_ok -> fetch_data_ok=0, drop_cnt=1, state REQ next cycle; redirect in REQ with addr_ok=0 -> no drop, inst_req stays high.
- DROP_CNT_W=2, 5 stale responses -> drop_cnt 1,2,3,3,3 (saturates).
- resetn=0 asserted in WAIT and HOLD -> next cycle IDLE with all outputs at reset values and drop_cnt=0.
